// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, FSM state encoding and the one-hot helper for the
// 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters and the arbiter.
interface mux8_rr_arbiter_if;
  import mux8_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             sel0;
  logic             sel1;
  logic             sel2;
  logic             valid;

  modport master (
    output req,
    input  grant, sel0, sel1, sel2, valid
  );

  modport slave (
    input  req,
    output grant, sel0, sel1, sel2, valid
  );
endinterface

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo 8.
module rr_pick_8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path through the block can infer a latch.
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan from the farthest offset inward so the nearest hit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        idx = ptr + SEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a shared 8:1 mux.
// The grant, select and valid outputs are all registered, and each owner keeps the grant for at most MAX_HOLD cycles.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  mux8_rr_arbiter_if.slave  bus
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_now;

  // While granted, sel_q is the owner; a release re-picks starting just past it.
  assign pick_ptr    = (state == ST_GRANT) ? sel_q + SEL_W'(1) : ptr;
  assign release_now = !bus.req[sel_q] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  rr_pick_8 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            grant_q  <= onehot(pick_idx);
            sel_q    <= pick_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr <= pick_ptr;
            if (pick_any) begin
              // Hand over on the same edge; may re-grant the same owner.
              grant_q  <= onehot(pick_idx);
              sel_q    <= pick_idx;
              hold_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              grant_q  <= '0;
              valid_q  <= 1'b0;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.sel0  = sel_q[2];
  assign bus.sel1  = sel_q[1];
  assign bus.sel2  = sel_q[0];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter. Expected outputs are queued as each
// stimulus is driven and are checked one clock edge later.
module tb_mux8_rr_arbiter;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input logic [7:0] g, input logic [2:0] s,
                            input logic v, input string tag);
    sb.push_back('{grant: g, sel: s, valid: v, tag: tag});
  endtask

  task automatic compare_head();
    exp_t e;
    logic [2:0] sel_obs;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty: got no expectation, need one");
      return;
    end
    e = sb.pop_front();
    sel_obs = {bus.sel0, bus.sel1, bus.sel2};
    total++;
    assert (bus.grant === e.grant) else begin
      bad++;
      $error("FAIL %s grant: got=%h want=%h", e.tag, bus.grant, e.grant);
    end
    total++;
    assert (sel_obs === e.sel) else begin
      bad++;
      $error("FAIL %s sel: got=%b want=%b", e.tag, sel_obs, e.sel);
    end
    total++;
    assert (bus.valid === e.valid) else begin
      bad++;
      $error("FAIL %s valid: got=%b want=%b", e.tag, bus.valid, e.valid);
    end
  endtask

  // Drive req, expect the given outputs after the next rising edge.
  task automatic step(input logic [7:0] r, input logic [7:0] g,
                      input logic [2:0] s, input logic v, input string tag);
    bus.req = r;
    expect_out(g, s, v, tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 8'h00;
    #1;
    expect_out(8'h00, 3'b000, 1'b0, "reset");
    compare_head();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int         k;
    logic [7:0] g;

    rst     = 1'b1;
    bus.req = 8'h00;
    #12;
    expect_out(8'h00, 3'b000, 1'b0, "t1_in_reset");
    compare_head();
    rst = 1'b0;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) step(8'h00, 8'h00, 3'b000, 1'b0, "t1_idle");

    // 2: single requester keeps the grant across limit releases
    for (int c = 0; c < 10; c++) step(8'h01, 8'h01, 3'b000, 1'b1, "t2_single");
    step(8'h00, 8'h00, 3'b000, 1'b0, "t2_drop");

    // 3: two requesters alternate every 4 cycles with no idle gap
    do_reset();
    for (int c = 0; c < 4; c++) step(8'h81, 8'h01, 3'b000, 1'b1, "t3_own0");
    for (int c = 0; c < 4; c++) step(8'h81, 8'h80, 3'b111, 1'b1, "t3_own7");
    for (int c = 0; c < 4; c++) step(8'h81, 8'h01, 3'b000, 1'b1, "t3_own0b");

    // 4: early release hands over; a new request does not preempt
    do_reset();
    step(8'h08, 8'h08, 3'b011, 1'b1, "t4_own3");
    step(8'h08, 8'h08, 3'b011, 1'b1, "t4_own3_hold");
    step(8'h40, 8'h40, 3'b110, 1'b1, "t4_handover6");
    for (int c = 0; c < 3; c++) step(8'h60, 8'h40, 3'b110, 1'b1, "t4_no_preempt");
    step(8'h60, 8'h20, 3'b101, 1'b1, "t4_own5");
    step(8'h00, 8'h00, 3'b101, 1'b0, "t4_idle_sel_kept");

    // 5: all requesting, full rotation plus wrap to 0
    do_reset();
    for (int c = 0; c < 36; c++) begin
      k = (c / 4) % 8;
      g = 8'h01 << k;
      step(8'hFF, g, 3'(k), 1'b1, "t5_rotate");
    end

    // 6: asynchronous reset mid-burst, then the pointer restarts at 0
    do_reset();
    step(8'h10, 8'h10, 3'b100, 1'b1, "t6_own4");
    step(8'h10, 8'h10, 3'b100, 1'b1, "t6_own4_hold");
    #3;
    rst = 1'b1;
    #1;
    expect_out(8'h00, 3'b000, 1'b0, "t6_async_rst");
    compare_head();
    bus.req = 8'h12;
    @(negedge clk);
    rst = 1'b0;
    step(8'h12, 8'h02, 3'b001, 1'b1, "t6_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
